dice_button_conditioner: RTL and testbench

//  Upstream stage of the dice roller. Turns NUM_BTN raw, bouncy, asynchronous push-buttons into clean

---
 rtl/dice_button_conditioner_pkg.sv | 18 +
 rtl/dice_button_conditioner_btn_debounce_cell.sv | 55 +++++
 rtl/dice_button_conditioner.sv | 126 ++++++++++++
 tb/tb_dice_button_conditioner.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_button_conditioner_pkg.sv
// Shared defaults and lock-FSM encoding for the dice roller button front end.
package dice_button_conditioner_pkg;

    localparam int NUM_BTN_DEF        = 7;
    localparam int DEBOUNCE_TICKS_DEF = 3;
    localparam int STUCK_TICKS_DEF    = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        DRAIN  = 2'd2
    } lock_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dice_button_conditioner_btn_debounce_cell.sv
// One button: two-flop synchroniser followed by a tick-driven debounce counter.
module btn_debounce_cell
    import dice_button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level
);

    localparam int CW = max_int($clog2(DEBOUNCE_TICKS + 1), 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic          sync1_q;
    logic          sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any tick that agrees with the current level restarts the count, so a
    // flip needs DEBOUNCE_TICKS consecutive disagreeing ticks.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (tick) begin
            if (sync_q == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync_q  <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/dice_button_conditioner.sv
// Debounces the dice buttons, grants a single owner per press and guards against stuck buttons.
module dice_button_conditioner
    import dice_button_conditioner_pkg::*;
#(
    parameter int NUM_BTN        = NUM_BTN_DEF,
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
    parameter int STUCK_TICKS    = STUCK_TICKS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_held,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic               any_held,
    output logic               stuck
);

    localparam int OW = max_int($clog2(NUM_BTN), 1);
    localparam int SW = max_int($clog2(STUCK_TICKS + 1), 8);
    localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_TICKS);

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] level_dly_q;
    logic [NUM_BTN-1:0] rise;
    logic [OW-1:0]      rise_idx;

    lock_state_e        state_q, state_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [SW-1:0]      stuck_cnt_q, stuck_cnt_d;
    logic [NUM_BTN-1:0] pulse_q, pulse_d;
    logic [NUM_BTN-1:0] held_q, held_d;
    logic               stuck_q, stuck_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
        btn_debounce_cell #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .tick (tick),
            .raw  (btn_raw[i]),
            .level(level[i])
        );
    end

    assign rise = level & ~level_dly_q;

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        rise_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (rise[i]) rise_idx = OW'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        stuck_cnt_d = stuck_cnt_q;
        pulse_d     = '0;
        case (state_q)
            IDLE: begin
                stuck_cnt_d = '0;
                if (|rise) begin
                    owner_d = rise_idx;
                    pulse_d = NUM_BTN'(1) << rise_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (tick && (stuck_cnt_q != STUCK_MAX)) stuck_cnt_d = stuck_cnt_q + SW'(1);
                if (!level[owner_q]) begin
                    if (level == '0) begin
                        state_d     = IDLE;
                        stuck_cnt_d = '0;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Stuck indication survives the drain and only clears once everything is released.
                if (level == '0) begin
                    state_d     = IDLE;
                    stuck_cnt_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                stuck_cnt_d = '0;
            end
        endcase
    end

    assign stuck_d = (stuck_cnt_d == STUCK_MAX);
    assign held_d  = ((state_d == LOCKED) && !stuck_d) ? (NUM_BTN'(1) << owner_d) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_dly_q <= '0;
            state_q     <= IDLE;
            owner_q     <= '0;
            stuck_cnt_q <= '0;
            pulse_q     <= '0;
            held_q      <= '0;
            stuck_q     <= 1'b0;
        end else begin
            level_dly_q <= level;
            state_q     <= state_d;
            owner_q     <= owner_d;
            stuck_cnt_q <= stuck_cnt_d;
            pulse_q     <= pulse_d;
            held_q      <= held_d;
            stuck_q     <= stuck_d;
        end
    end

    assign btn_level   = level;
    assign btn_held    = held_q;
    assign press_pulse = pulse_q;
    assign any_held    = |held_q;
    assign stuck       = stuck_q;

endmodule

// File: tb/tb_dice_button_conditioner.sv
// Directed bench: vector table for press/chord/late-press, hand sequences for bounce, stuck and reset.
module tb_dice_button_conditioner;

    localparam int NB       = 7;
    localparam int TICK_PER = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level, btn_held, press_pulse;
    logic          any_held, stuck;
    logic [NB-1:0] raw_s = '0;
    logic [NB-1:0] lvl_s, held_s, pulse_s;
    logic          any_s, stuck_s;

    int n_vec = 0;
    int n_err = 0;

    dice_button_conditioner dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_held   (btn_held),
        .press_pulse(press_pulse),
        .any_held   (any_held),
        .stuck      (stuck)
    );

    dice_button_conditioner #(.STUCK_TICKS(4)) dut_s (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .btn_raw    (raw_s),
        .btn_level  (lvl_s),
        .btn_held   (held_s),
        .press_pulse(pulse_s),
        .any_held   (any_s),
        .stuck      (stuck_s)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (TICK_PER - 1) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    int            pulse_seen = 0;
    int            rise1_seen = 0;
    int            multi_hot  = 0;
    logic [NB-1:0] last_pulse = '0;
    logic [NB-1:0] lvl_prev   = '0;

    always @(posedge clk) begin
        lvl_prev <= btn_level;
        if (press_pulse != '0) begin
            pulse_seen <= pulse_seen + 1;
            last_pulse <= press_pulse;
        end
        if (btn_level[1] && !lvl_prev[1]) rise1_seen <= rise1_seen + 1;
        if (!$onehot0(press_pulse) || !$onehot0(pulse_s)) multi_hot <= multi_hot + 1;
    end

    // Wait nt tick edges, then nc more clock edges, then settle 1 time unit past the edge.
    task automatic run(input int nt, input int nc);
        for (int i = 0; i < nt; i++) begin
            int guard;
            guard = 0;
            @(posedge clk);
            while (!tick && guard < 4 * TICK_PER) begin
                @(posedge clk);
                guard++;
            end
            if (guard >= 4 * TICK_PER) begin
                n_err++;
                $display("FAIL tick_timeout: no tick within %0d clk", 4 * TICK_PER);
            end
        end
        for (int i = 0; i < nc; i++) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [NB-1:0] al, input logic [NB-1:0] ah, input logic [NB-1:0] ap,
                         input logic aa, input logic ast,
                         input logic [NB-1:0] el, input logic [NB-1:0] eh, input logic [NB-1:0] ep,
                         input logic est);
        n_vec++;
        if (al !== el || ah !== eh || ap !== ep || aa !== (|eh) || ast !== est) begin
            n_err++;
            $display("FAIL %s: got level=%h held=%h pulse=%h any=%b stuck=%b, want level=%h held=%h pulse=%h any=%b stuck=%b",
                     name, al, ah, ap, aa, ast, el, eh, ep, |eh, est);
        end
    endtask

    task automatic chk_m(input string name, input logic [NB-1:0] el, input logic [NB-1:0] eh,
                         input logic [NB-1:0] ep, input logic est);
        check(name, btn_level, btn_held, press_pulse, any_held, stuck, el, eh, ep, est);
    endtask

    task automatic chk_s(input string name, input logic [NB-1:0] el, input logic [NB-1:0] eh,
                         input logic [NB-1:0] ep, input logic est);
        check(name, lvl_s, held_s, pulse_s, any_s, stuck_s, el, eh, ep, est);
    endtask

    typedef struct {
        string         name;
        logic [NB-1:0] raw;
        int            nt;
        int            nc;
        logic [NB-1:0] lvl;
        logic [NB-1:0] held;
        logic [NB-1:0] pulse;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string name, input logic [NB-1:0] raw, input int nt, input int nc,
                                input logic [NB-1:0] lvl, input logic [NB-1:0] held,
                                input logic [NB-1:0] pulse);
        vec_t v;
        v.name = name; v.raw = raw; v.nt = nt; v.nc = nc;
        v.lvl = lvl; v.held = held; v.pulse = pulse;
        return v;
    endfunction

    initial begin
        int p0, r0;

        // Clean press of bit 3, hold, release
        tbl.push_back(mk("t1_pre",        7'h08, 2, 0, 7'h00, 7'h00, 7'h00));
        tbl.push_back(mk("t1_level",      7'h08, 1, 0, 7'h08, 7'h00, 7'h00));
        tbl.push_back(mk("t1_pulse",      7'h08, 0, 1, 7'h08, 7'h08, 7'h08));
        tbl.push_back(mk("t1_pulse_end",  7'h08, 0, 1, 7'h08, 7'h08, 7'h00));
        tbl.push_back(mk("t1_hold",       7'h08, 2, 0, 7'h08, 7'h08, 7'h00));
        tbl.push_back(mk("t1_rel_pre",    7'h00, 2, 0, 7'h08, 7'h08, 7'h00));
        tbl.push_back(mk("t1_rel_lvl",    7'h00, 1, 0, 7'h00, 7'h08, 7'h00));
        tbl.push_back(mk("t1_idle",       7'h00, 0, 1, 7'h00, 7'h00, 7'h00));
        // Chord of bits 2 and 5
        tbl.push_back(mk("t3_chord_lvl",  7'h24, 3, 0, 7'h24, 7'h00, 7'h00));
        tbl.push_back(mk("t3_pulse",      7'h24, 0, 1, 7'h24, 7'h04, 7'h04));
        tbl.push_back(mk("t3_owned",      7'h24, 0, 1, 7'h24, 7'h04, 7'h00));
        tbl.push_back(mk("t3_rel2_lvl",   7'h20, 3, 0, 7'h20, 7'h04, 7'h00));
        tbl.push_back(mk("t3_drain",      7'h20, 0, 1, 7'h20, 7'h00, 7'h00));
        tbl.push_back(mk("t3_drain_hold", 7'h20, 1, 0, 7'h20, 7'h00, 7'h00));
        tbl.push_back(mk("t3_rel5_lvl",   7'h00, 3, 0, 7'h00, 7'h00, 7'h00));
        tbl.push_back(mk("t3_idle",       7'h00, 0, 1, 7'h00, 7'h00, 7'h00));
        // Own bit 0, then a late press of bit 6
        tbl.push_back(mk("t4_pre",        7'h01, 3, 0, 7'h01, 7'h00, 7'h00));
        tbl.push_back(mk("t4_pulse",      7'h01, 0, 1, 7'h01, 7'h01, 7'h01));
        tbl.push_back(mk("t4_late_lvl",   7'h41, 3, 0, 7'h41, 7'h01, 7'h00));
        tbl.push_back(mk("t4_no_pulse",   7'h41, 0, 1, 7'h41, 7'h01, 7'h00));
        tbl.push_back(mk("t4_still",      7'h41, 0, 1, 7'h41, 7'h01, 7'h00));
        tbl.push_back(mk("t4_rel_lvl",    7'h00, 3, 0, 7'h00, 7'h01, 7'h00));
        tbl.push_back(mk("t4_idle",       7'h00, 0, 1, 7'h00, 7'h00, 7'h00));

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_m("reset_main", 7'h00, 7'h00, 7'h00, 1'b0);
        chk_s("reset_stuck", 7'h00, 7'h00, 7'h00, 1'b0);
        rst = 1'b0;

        run(1, 0);
        foreach (tbl[i]) begin
            btn_raw = tbl[i].raw;
            run(tbl[i].nt, tbl[i].nc);
            chk_m(tbl[i].name, tbl[i].lvl, tbl[i].held, tbl[i].pulse, 1'b0);
        end

        // Bounce on bit 1: 2 ticks high, 1 tick low, five times, then steady
        run(1, 0);
        p0 = pulse_seen;
        r0 = rise1_seen;
        for (int k = 0; k < 5; k++) begin
            btn_raw = 7'h02;
            run(2, 0);
            btn_raw = 7'h00;
            run(1, 0);
        end
        chk_m("t2_bounce_quiet", 7'h00, 7'h00, 7'h00, 1'b0);
        btn_raw = 7'h02;
        run(3, 0);
        chk_m("t2_level", 7'h02, 7'h00, 7'h00, 1'b0);
        run(0, 1);
        chk_m("t2_pulse", 7'h02, 7'h02, 7'h02, 1'b0);
        run(0, 1);
        chk_m("t2_pulse_end", 7'h02, 7'h02, 7'h00, 1'b0);
        n_vec++;
        if (pulse_seen - p0 != 1 || rise1_seen - r0 != 1 || last_pulse !== 7'h02) begin
            n_err++;
            $display("FAIL t2_counts: got pulses=%0d rises=%0d last=%h, want pulses=1 rises=1 last=02",
                     pulse_seen - p0, rise1_seen - r0, last_pulse);
        end
        btn_raw = 7'h00;
        run(3, 1);
        chk_m("t2_release", 7'h00, 7'h00, 7'h00, 1'b0);

        // Stuck guard on the STUCK_TICKS=4 instance, bit 4
        run(1, 0);
        raw_s = 7'h10;
        run(3, 0);
        chk_s("t5_level", 7'h10, 7'h00, 7'h00, 1'b0);
        run(0, 1);
        chk_s("t5_locked", 7'h10, 7'h10, 7'h10, 1'b0);
        run(3, 0);
        chk_s("t5_tick3", 7'h10, 7'h10, 7'h00, 1'b0);
        run(1, 0);
        chk_s("t5_stuck", 7'h10, 7'h00, 7'h00, 1'b1);
        run(2, 0);
        chk_s("t5_stuck_hold", 7'h10, 7'h00, 7'h00, 1'b1);
        raw_s = 7'h00;
        run(3, 0);
        chk_s("t5_rel_lvl", 7'h00, 7'h00, 7'h00, 1'b1);
        run(0, 1);
        chk_s("t5_idle", 7'h00, 7'h00, 7'h00, 1'b0);

        // Reset while bit 3 is owned and still physically held
        run(1, 0);
        btn_raw = 7'h08;
        run(3, 1);
        chk_m("t6_locked", 7'h08, 7'h08, 7'h08, 1'b0);
        rst = 1'b1;
        run(0, 1);
        rst = 1'b0;
        chk_m("t6_reset", 7'h00, 7'h00, 7'h00, 1'b0);
        run(2, 0);
        chk_m("t6_pre", 7'h00, 7'h00, 7'h00, 1'b0);
        run(1, 0);
        chk_m("t6_level", 7'h08, 7'h00, 7'h00, 1'b0);
        run(0, 1);
        chk_m("t6_pulse", 7'h08, 7'h08, 7'h08, 1'b0);
        btn_raw = 7'h00;
        run(3, 1);
        chk_m("t6_idle", 7'h00, 7'h00, 7'h00, 1'b0);

        n_vec++;
        if (multi_hot != 0) begin
            n_err++;
            $display("FAIL pulse_onehot: got %0d multi-hot pulse cycles, want 0", multi_hot);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
